// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared FSM states and baud divisor helper for uart_tx_fifo
package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Rounded-to-nearest clock cycles per bit.
   function automatic int calc_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - power-of-two synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_err
      $error("sync_fifo: DEPTH must be a power of two in 2..256");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter fed from the I/O bus write strobe
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200,
   parameter int DEPTH    = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     uart_we,
   input  logic [7:0]               uart_data_in,
   output logic                     uart_ready,
   output logic                     uart_txd,
   output logic                     tx_busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_err
      $error("uart_tx_fifo: baud divisor below 2");
   end

   state_t         state;
   logic [CW-1:0]  baud_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic [7:0]     head;
   logic           full;
   logic           empty;
   logic           baud_done;
   logic           pop;

   assign baud_done  = (baud_cnt == LAST);
   assign uart_ready = !full;
   assign tx_busy    = (state != IDLE);

   // Pop when IDLE sees data, or when a stop bit ends with more data waiting.
   assign pop = !empty && ((state == IDLE) || (state == STOP && baud_done));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (uart_we),
      .pop   (pop),
      .wdata (uart_data_in),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow <= 1'b0;
      end else if (uart_we && !uart_ready) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         uart_txd <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               uart_txd <= 1'b1;
               if (!empty) begin
                  shreg    <= head;
                  uart_txd <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  uart_txd <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     uart_txd <= 1'b1;
                     state    <= STOP;
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     uart_txd <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (!empty) begin
                     shreg    <= head;
                     uart_txd <= 1'b0;
                     state    <= START;
                  end else begin
                     state    <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               uart_txd <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo at DIV = 10, DEPTH = 16
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       uart_we = 1'b0;
   logic [7:0] uart_data_in = 8'h00;
   logic       uart_ready;
   logic       uart_txd;
   logic       tx_busy;
   logic [4:0] fifo_count;
   logic       overflow;

   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         frames = 0;
   logic [7:0] exp_q [$];
   int         start_q [$];

   bit         mon_active = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'h00;

   uart_tx_fifo #(
      .CLK_FREQ (1_000_000),
      .BAUD     (100_000),
      .DEPTH    (16)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .uart_we      (uart_we),
      .uart_data_in (uart_data_in),
      .uart_ready   (uart_ready),
      .uart_txd     (uart_txd),
      .tx_busy      (tx_busy),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame monitor: samples mid-bit, offsets counted from the first low sample.
   always @(negedge clk) begin
      if (!rstn) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (uart_txd === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            start_q.push_back(cyc);
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == 5) begin
            check("start_bit", 32'(uart_txd), 32'd0);
         end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
            mon_byte[(mon_cnt - 15) / 10] = uart_txd;
         end else if (mon_cnt == 95) begin
            check("stop_bit", 32'(uart_txd), 32'd1);
            frames++;
            mon_active = 1'b0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
            end else begin
               check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic wr(input logic [7:0] b, input bit accepted);
      uart_we      = 1'b1;
      uart_data_in = b;
      if (accepted) exp_q.push_back(b);
      @(posedge clk);
      #1;
      uart_we = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   int e0;
   int f0;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(uart_txd), 32'd1);
      check("rst_ready", 32'(uart_ready), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // single 0x55 frame and its exact timing
      f0 = frames;
      wr(8'h55, 1'b1);
      e0 = cyc;
      check("t1_count_after_write", 32'(fifo_count), 32'd1);
      check("t1_txd_at_E", 32'(uart_txd), 32'd1);
      wait_until(e0 + 1);
      check("t1_txd_at_E1", 32'(uart_txd), 32'd0);
      check("t1_busy_at_E1", 32'(tx_busy), 32'd1);
      check("t1_count_at_E1", 32'(fifo_count), 32'd0);
      wait_until(e0 + 100);
      check("t1_busy_at_E100", 32'(tx_busy), 32'd1);
      wait_until(e0 + 101);
      check("t1_busy_at_E101", 32'(tx_busy), 32'd0);
      check("t1_txd_at_E101", 32'(uart_txd), 32'd1);
      wait_until(e0 + 110);
      check("t1_frames", 32'(frames - f0), 32'd1);

      // three back-to-back frames
      f0 = frames;
      start_q.delete();
      wr(8'hA5, 1'b1);
      e0 = cyc;
      wr(8'h00, 1'b1);
      wr(8'hFF, 1'b1);
      wait_until(e0 + 310);
      check("t2_frames", 32'(frames - f0), 32'd3);
      check("t2_starts", 32'(start_q.size()), 32'd3);
      if (start_q.size() >= 3) begin
         check("t2_gap_01", 32'(start_q[1] - start_q[0]), 32'd100);
         check("t2_gap_12", 32'(start_q[2] - start_q[1]), 32'd100);
      end
      check("t2_busy_end", 32'(tx_busy), 32'd0);

      // fill to full, overflow, then pop-at-stop with a dropped write
      f0 = frames;
      for (int i = 0; i < 18; i++) begin
         wr(8'h10 + 8'(i), i < 17);
         if (i == 0) e0 = cyc;
         if (i == 1) check("t3_count_E1", 32'(fifo_count), 32'd1);
         if (i == 16) begin
            check("t3_count_full", 32'(fifo_count), 32'd16);
            check("t3_ready_full", 32'(uart_ready), 32'd0);
            check("t3_no_overflow_yet", 32'(overflow), 32'd0);
         end
      end
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_count_after_drop", 32'(fifo_count), 32'd16);
      wait_until(e0 + 100);
      check("t4_ready_before_pop", 32'(uart_ready), 32'd0);
      check("t4_count_before_pop", 32'(fifo_count), 32'd16);
      wr(8'hEE, 1'b0);
      check("t4_count_after_pop", 32'(fifo_count), 32'd15);
      check("t4_ready_after_pop", 32'(uart_ready), 32'd1);
      check("t4_next_start", 32'(uart_txd), 32'd0);
      wait_until(e0 + 1710);
      check("t3_frames", 32'(frames - f0), 32'd17);
      check("t3_queue_drained", 32'(exp_q.size()), 32'd0);
      check("t3_busy_end", 32'(tx_busy), 32'd0);
      check("t3_count_end", 32'(fifo_count), 32'd0);

      // reset in the middle of a frame with three bytes queued
      f0 = frames;
      wr(8'hC1, 1'b0);
      e0 = cyc;
      wr(8'hC2, 1'b0);
      wr(8'hC3, 1'b0);
      wr(8'hC4, 1'b0);
      check("t5_count_queued", 32'(fifo_count), 32'd3);
      wait_until(e0 + 46);
      #2;
      rstn = 1'b0;
      #1;
      check("t5_txd_in_reset", 32'(uart_txd), 32'd1);
      check("t5_count_in_reset", 32'(fifo_count), 32'd0);
      check("t5_ready_in_reset", 32'(uart_ready), 32'd1);
      check("t5_overflow_in_reset", 32'(overflow), 32'd0);
      check("t5_busy_in_reset", 32'(tx_busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      e0 = cyc;
      wait_until(e0 + 200);
      check("t5_no_frames", 32'(frames - f0), 32'd0);
      check("t5_txd_idle", 32'(uart_txd), 32'd1);
      check("t5_busy_idle", 32'(tx_busy), 32'd0);

      // push and pop in the same cycle at count 5, order preserved
      f0 = frames;
      wr(8'h31, 1'b1);
      e0 = cyc;
      wr(8'h32, 1'b1);
      wr(8'h33, 1'b1);
      wr(8'h34, 1'b1);
      wr(8'h35, 1'b1);
      wr(8'h36, 1'b1);
      check("t6_count5", 32'(fifo_count), 32'd5);
      wait_until(e0 + 100);
      check("t6_count_before", 32'(fifo_count), 32'd5);
      wr(8'h37, 1'b1);
      check("t6_count_same", 32'(fifo_count), 32'd5);
      check("t6_restart", 32'(uart_txd), 32'd0);
      wait_until(e0 + 720);
      check("t6_frames", 32'(frames - f0), 32'd7);
      check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
      check("t6_busy_end", 32'(tx_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
